// File: rtl/sw_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : sw_debouncer
// Purpose  : Per-bit 2-flop synchroniser and counter debouncer for board
//            switches, with registered rise/fall pulses and a busy flag.
//            Optional macro SW_RUN_TOGGLE_EN turns o_sw[0] into a run/stop
//            toggle driven by rising edges of debounced bit 0.
// Revision : 1.0 - initial release
// ============================================================================
module sw_debouncer #(
    parameter int NB_SW      = 4,
    parameter int NB_DEB     = 20,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_sw,
    output logic [NB_SW-1:0] o_rise,
    output logic [NB_SW-1:0] o_fall,
    output logic             o_busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam logic [NB_DEB-1:0] C_LAST = NB_DEB'(DEB_CYCLES - 1);
    localparam logic [NB_DEB-1:0] C_ONE  = NB_DEB'(1);

    logic [NB_SW-1:0] deb_w;
    logic [NB_SW-1:0] busy_w;
`ifdef SW_RUN_TOGGLE_EN
    logic [NB_SW-1:0] deb_next_w;
`endif

    for (genvar i = 0; i < NB_SW; i++) begin : g_bit
        logic              s1_q, s2_q;
        logic              deb_q, deb_d;
        logic              rise_q, rise_d;
        logic              fall_q, fall_d;
        state_t            state_q, state_d;
        logic [NB_DEB-1:0] cnt_q, cnt_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            deb_d   = deb_q;
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (s2_q != deb_q) begin
                        // A one-cycle window accepts the new level on the first differing edge.
                        if (DEB_CYCLES == 1) begin
                            deb_d = s2_q;
                        end else begin
                            state_d = ST_COUNT;
                            cnt_d   = C_ONE;
                        end
                    end
                end
                ST_COUNT: begin
                    if (s2_q == deb_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == C_LAST) begin
                        deb_d   = s2_q;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            rise_d = deb_d & ~deb_q;
            fall_d = ~deb_d & deb_q;
        end

        always_ff @(posedge clk or negedge i_reset) begin
            if (!i_reset) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                deb_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                s1_q    <= i_sw[i];
                s2_q    <= s1_q;
                deb_q   <= deb_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign deb_w[i]  = deb_q;
        assign busy_w[i] = (state_q == ST_COUNT);
        assign o_rise[i] = rise_q;
        assign o_fall[i] = fall_q;
`ifdef SW_RUN_TOGGLE_EN
        assign deb_next_w[i] = deb_d;
`endif
    end : g_bit

    assign o_busy = |busy_w;

`ifdef SW_RUN_TOGGLE_EN
    logic toggle_q, toggle_d;

    // Flip on the same edge the debounced bit 0 goes high, so it lines up with o_rise[0].
    always_comb begin
        toggle_d = toggle_q ^ (deb_next_w[0] & ~deb_w[0]);
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    always_comb begin
        o_sw    = deb_w;
        o_sw[0] = toggle_q;
    end
`else
    assign o_sw = deb_w;
`endif

endmodule : sw_debouncer
`default_nettype wire

// File: doc/sw_debouncer.md
Name: sw_debouncer

Overview:
- Input-conditioning stage that sits directly upstream of the LED shift stage.
- Takes raw, asynchronous board switches and synchronises them into the clk domain.
- Debounces each bit independently and delivers clean switch levels. These drive the shift enable, speed select and colour select.
- Also produces one-cycle rise/fall pulses per bit, for control logic that needs edge events.

Parameters:
- NB_SW, 4: number of switch bits processed; each bit has its own synchroniser and debounce counter.
- NB_DEB, 20: width of each per-bit debounce counter.
- DEB_CYCLES, 1000000: number of consecutive clk cycles a synchronised level must differ from the current output before it is accepted. Range 1..2**NB_DEB-1; the default is 10 ms at 100 MHz.

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- i_reset  input  1  reset, asynchronous and active-low. Assertion (0) clears all state immediately; release is sampled on clk.
- i_sw  input  NB_SW  raw asynchronous switch levels.
- o_sw  output  NB_SW  debounced switch levels.
- o_rise  output  NB_SW  one-cycle pulse on the cycle o_sw[i] goes 0->1.
- o_fall  output  NB_SW  one-cycle pulse on the cycle o_sw[i] goes 1->0.
- o_busy  output  1  OR of all per-bit "counting" flags (a transition is in qualification).

Behaviour:
- Reset (i_reset=0): sync stages, counters, o_sw, o_rise, o_fall and o_busy all become 0, asynchronously.
- Synchroniser: per bit, two flops s1 <= i_sw[i], s2 <= s1. Only s2 is used downstream.
- Per-bit state machine, states IDLE and COUNT:
  - IDLE (s2 == o_sw[i]): counter held at 0.
  - IDLE -> COUNT when s2 != o_sw[i]. On that same edge the counter goes to 1, or o_sw[i] updates at once if DEB_CYCLES == 1.
  - COUNT, s2 still differs and counter < DEB_CYCLES-1: counter += 1.
  - COUNT, s2 still differs and counter == DEB_CYCLES-1: o_sw[i] <= s2, counter <= 0, return to IDLE. The matching o_rise[i] or o_fall[i] is 1 for exactly this following cycle.
  - COUNT, s2 == o_sw[i] (glitch shorter than the window): counter <= 0, return to IDLE, no output change, no pulse.
- Latency: a clean level change on i_sw[i], first sampled at edge E, appears on o_sw[i] after edge E+DEB_CYCLES+1. That is 2 sync cycles plus DEB_CYCLES qualification cycles, minus the overlap on the first qualifying edge.
- Counter arithmetic: unsigned NB_DEB bits. It never exceeds DEB_CYCLES-1, so it never wraps.
- Pulses: o_rise and o_fall are registered, deasserted the cycle after assertion, and never both 1 for the same bit.
- Bits are fully independent. Simultaneous transitions on several bits each qualify and pulse on their own schedule; same-cycle pulses on different bits are allowed.
- o_busy: combinational OR of (state == COUNT) over all bits.
- Reset mid-count: counter and state are discarded; after release the bit restarts from o_sw = 0. If the switch is high at release, o_sw[i] rises DEB_CYCLES+1 edges after the first sampling edge and o_rise[i] pulses.

Optional Feature:
- Macro: SW_RUN_TOGGLE_EN.
- Defined: o_sw[0] is a toggle register, reset 0, that inverts on each cycle where the internal debounced bit 0 rises. A pushbutton on bit 0 therefore acts as run/stop. o_rise[0]/o_fall[0] still reflect the internal debounced level, not the toggle.
- Undefined: o_sw[0] is the plain debounced level, identical to the other bits.

Test Plan:
All scenarios use NB_SW=4, NB_DEB=4, DEB_CYCLES=4.
- Reset, then i_sw=4'b0000 held 20 cycles -> o_sw=0, o_rise=o_fall=0, o_busy=0 throughout.
- i_sw[0] 0->1 held stable -> o_sw[0]=1 exactly 5 edges after the first sampling edge; o_rise[0]=1 for one cycle; o_busy=1 for 3 cycles before the update.
- i_sw[1] bounce 1,0,1,0 for 3 cycles each, then stable 1 -> no o_sw[1] change and no pulse during the bounce; o_sw[1]=1 only after 4 stable cycles.
- i_sw=4'b1010 applied in one cycle -> o_sw[3] and o_sw[1] rise on the same edge; o_rise=4'b1010 for one cycle.
- Counting on bit 2, i_reset driven 0 mid-count -> o_sw, o_busy, counters 0 immediately (before the next clk edge); after release with i_sw[2]=1, o_sw[2] rises after 5 edges.
- SW_RUN_TOGGLE_EN defined, three clean presses/releases on i_sw[0] -> o_sw[0] goes 1,0,1 after each press qualifies; unchanged on releases.
